friet_lwc_fifo_in: RTL



---
 rtl/friet_lwc_fifo_in.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/friet_lwc_fifo_in.sv
`default_nettype none
// ============================================================================
//  Module   : friet_lwc_fifo_in
//  Brief    : Parametrised input FIFO for the FRIET LWC datapath. Stores up to
//             2^G_LOG2_DEPTH words of G_WIDTH bits between two valid/ready
//             handshakes, reports occupancy on level, and optionally supports
//             a synchronous flush (build macro FRIET_LWC_FIFO_FLUSH_EN).
//  Revision : 1.0 - initial multi-entry release
// ============================================================================
module friet_lwc_fifo_in #(
    parameter int G_WIDTH      = 32,
    parameter int G_LOG2_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [G_WIDTH-1:0]      din,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [G_WIDTH-1:0]      dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
`ifdef FRIET_LWC_FIFO_FLUSH_EN
    input  logic                    flush,
`endif
    output logic [G_LOG2_DEPTH:0]   level
);

    localparam logic [G_LOG2_DEPTH:0]   c_DEPTH    = {1'b1, {G_LOG2_DEPTH{1'b0}}};
    localparam logic [G_LOG2_DEPTH:0]   c_LVL_ONE  = (G_LOG2_DEPTH+1)'(1);
    localparam logic [G_LOG2_DEPTH-1:0] c_PTR_ONE  = G_LOG2_DEPTH'(1);
    localparam int                      c_ENTRIES  = 1 << G_LOG2_DEPTH;

    // Storage is deliberately not reset; only pointers and occupancy are.
    logic [G_WIDTH-1:0]      r_mem_q [0:c_ENTRIES-1];

    logic [G_LOG2_DEPTH-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [G_LOG2_DEPTH-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [G_LOG2_DEPTH:0]   r_level_q,  w_level_d;

    logic [G_LOG2_DEPTH-1:0] w_upd_wr_ptr;
    logic [G_LOG2_DEPTH-1:0] w_upd_rd_ptr;
    logic [G_LOG2_DEPTH:0]   w_upd_level;

    logic w_full;
    logic w_ready_run;
    logic w_push;
    logic w_pop;

    assign w_full     = (r_level_q == c_DEPTH);
    assign level      = r_level_q;
    assign dout_valid = (r_level_q != '0);
    assign dout       = r_mem_q[r_rd_ptr_q];
    assign w_push     = din_valid & din_ready;
    assign w_pop      = dout_valid & dout_ready;

    // Ready outside reset/flush: always when not full; when full only if a pop frees a slot.
    always_comb begin
        w_ready_run = 1'b1;
        if (!w_full) begin
            w_ready_run = 1'b1;
        end else if (dout_ready) begin
            w_ready_run = 1'b1;
        end else if (!dout_ready) begin
            w_ready_run = 1'b0;
        end else begin
            w_ready_run = 1'bx;
        end
    end

    // Final din_ready: blocked during reset and (when built in) during flush.
    always_comb begin
        din_ready = 1'b0;
        if (rst) begin
            din_ready = 1'b0;
        end else if (!rst) begin
`ifdef FRIET_LWC_FIFO_FLUSH_EN
            if (flush) begin
                din_ready = 1'b0;
            end else if (!flush) begin
                din_ready = w_ready_run;
            end else begin
                din_ready = 1'bx;
            end
`else
            din_ready = w_ready_run;
`endif
        end else begin
            din_ready = 1'bx;
        end
    end

    // Normal-operation pointer and occupancy update from the two handshakes.
    always_comb begin
        w_upd_wr_ptr = r_wr_ptr_q;
        w_upd_rd_ptr = r_rd_ptr_q;
        w_upd_level  = r_level_q;

        if (w_push) begin
            w_upd_wr_ptr = r_wr_ptr_q + c_PTR_ONE;
        end else if (!w_push) begin
            w_upd_wr_ptr = r_wr_ptr_q;
        end else begin
            w_upd_wr_ptr = 'x;
        end

        if (w_pop) begin
            w_upd_rd_ptr = r_rd_ptr_q + c_PTR_ONE;
        end else if (!w_pop) begin
            w_upd_rd_ptr = r_rd_ptr_q;
        end else begin
            w_upd_rd_ptr = 'x;
        end

        if (w_push && !w_pop) begin
            w_upd_level = r_level_q + c_LVL_ONE;
        end else if (!w_push && w_pop) begin
            w_upd_level = r_level_q - c_LVL_ONE;
        end else if (w_push == w_pop) begin
            w_upd_level = r_level_q;
        end else begin
            w_upd_level = 'x;
        end
    end

    // Next state: reset dominates, then flush (if built in), then normal update.
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_level_d  = r_level_q;
        if (rst) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_level_d  = '0;
        end else if (!rst) begin
`ifdef FRIET_LWC_FIFO_FLUSH_EN
            if (flush) begin
                w_wr_ptr_d = '0;
                w_rd_ptr_d = '0;
                w_level_d  = '0;
            end else if (!flush) begin
                w_wr_ptr_d = w_upd_wr_ptr;
                w_rd_ptr_d = w_upd_rd_ptr;
                w_level_d  = w_upd_level;
            end else begin
                w_wr_ptr_d = 'x;
                w_rd_ptr_d = 'x;
                w_level_d  = 'x;
            end
`else
            w_wr_ptr_d = w_upd_wr_ptr;
            w_rd_ptr_d = w_upd_rd_ptr;
            w_level_d  = w_upd_level;
`endif
        end else begin
            w_wr_ptr_d = 'x;
            w_rd_ptr_d = 'x;
            w_level_d  = 'x;
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        r_wr_ptr_q <= w_wr_ptr_d;
        r_rd_ptr_q <= w_rd_ptr_d;
        r_level_q  <= w_level_d;
    end

    // Data storage write; push is already suppressed during reset and flush.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr_q] <= din;
        end
    end

endmodule
`default_nettype wire
